// File: rtl/sm_hex_scan.sv
// sm_hex_scan: multi-digit hex scanner with frame-synchronous double-buffered updates.
// Ports:
//   clk, rst (async, active-high)
//   load, value[4*DIGITS-1:0]  capture value into the shadow register
//   digit[3:0]                 nibble of the selected position
//   digit_sel[DIGITS-1:0]      one-hot position select
//   blank                      position shown dark (leading-zero blanking)
//   frame                      one-cycle pulse after the frame wrap
//   pending                    shadow not yet applied to the display
// Define SM_HEX_SCAN_LZB_EN to enable leading-zero blanking; otherwise blank is tied low.
module sm_hex_scan #(
  parameter int DIGITS = 6,
  parameter int DIV_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            digit,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  blank,
  output logic                  frame,
  output logic                  pending
);
  localparam int IDX_W = $clog2(DIGITS);
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] active_q, active_d, shadow_q, shadow_d;
  logic                pending_q, pending_d, frame_q, frame_d;
  logic                tick, wrap;
  always_comb begin
    tick      = &cnt_q;
    wrap      = tick && (idx_q == IDX_W'(DIGITS - 1));
    cnt_d     = cnt_q + DIV_W'(1);
    idx_d     = tick ? (wrap ? '0 : idx_q + IDX_W'(1)) : idx_q;
    frame_d   = wrap;
    // active always takes the old shadow, so a load on the wrap edge waits one frame
    active_d  = (wrap && pending_q) ? shadow_q : active_q;
    shadow_d  = load ? value : shadow_q;
    pending_d = load ? 1'b1 : (wrap ? 1'b0 : pending_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
    end
  end
  always_comb begin
    digit     = '0;
    digit_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_sel[i] = (idx_q == IDX_W'(i));
      if (idx_q == IDX_W'(i)) digit = active_q[4*i +: 4];
    end
  end
`ifdef SM_HEX_SCAN_LZB_EN
  // dark when every digit from the current position upward is zero; position 0 always lit
  always_comb begin
    blank = (idx_q != '0);
    for (int i = 0; i < DIGITS; i++)
      if (IDX_W'(i) >= idx_q && active_q[4*i +: 4] != 4'h0) blank = 1'b0;
  end
`else
  assign blank = 1'b0;
`endif
  assign frame   = frame_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_sm_hex_scan.sv
// tb_sm_hex_scan: randomized and directed checks of sm_hex_scan against a time-based reference model.
module tb_sm_hex_scan;
  localparam int DIGITS = 6;
  localparam int DIV_W  = 2;
  localparam int DWELL  = 1 << DIV_W;
  localparam int FRAME  = DIGITS * DWELL;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [23:0] value = '0;
  logic [3:0]  digit;
  logic [5:0]  digit_sel;
  logic        blank, frame, pending;
  int          total = 0;
  int          bad = 0;
  int          n = 0;
  logic [23:0] act = '0;
  logic [23:0] shd = '0;
  bit          pend = 1'b0;
  bit          fr = 1'b0;

  sm_hex_scan #(.DIGITS(DIGITS), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .digit(digit), .digit_sel(digit_sel), .blank(blank),
    .frame(frame), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int  idx;
    bit  eb;
    idx = (n / DWELL) % DIGITS;
`ifdef SM_HEX_SCAN_LZB_EN
    eb = (idx > 0) && ((act >> (4 * idx)) == 24'h0);
`else
    eb = 1'b0;
`endif
    check("digit", 32'(digit), 32'((act >> (4 * idx)) & 24'hF));
    check("digit_sel", 32'(digit_sel), 32'(6'(1) << idx));
    check("blank", 32'(blank), 32'(eb));
    check("frame", 32'(frame), 32'(fr));
    check("pending", 32'(pending), 32'(pend));
  endtask

  // one clock edge with the given load/value, model update, then compare
  task automatic step(input bit l, input logic [23:0] v);
    bit w;
    load  = l;
    value = v;
    @(posedge clk);
    n++;
    w  = (n % FRAME) == 0;
    fr = w;
    if (w && pend) act = shd;
    if (l) begin
      shd  = v;
      pend = 1'b1;
    end else if (w) pend = 1'b0;
    #1;
    load = 1'b0;
    check_all();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 24'h0);
  endtask

  // advance until the next edge has edge number congruent to t mod FRAME
  task automatic run_to(input int t);
    while (((n + 1) % FRAME) != t) step(1'b0, 24'h0);
  endtask

  initial begin
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    // free run: scan order, frame pulses, zero display
    run(48);
    // load mid-frame at idx 2
    run_to(2 * DWELL + 1);
    step(1'b1, 24'h123456);
    run(FRAME);
    // two loads in one frame, only the last is shown
    run_to(5);
    step(1'b1, 24'hAAAAAA);
    run(3);
    step(1'b1, 24'h0000BC);
    run(FRAME + 4);
    // load on the exact wrap edge while shadow holds a pending value
    run_to(7);
    step(1'b1, 24'h111111);
    run_to(0);
    step(1'b1, 24'hFFFFFF);
    run(2 * FRAME);
    // leading-zero pattern
    step(1'b1, 24'h00A00B);
    run(2 * FRAME);
    // randomized loads
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) step(1'b1, 24'($urandom));
      else step(1'b0, 24'h0);
    end
    // asynchronous reset mid-frame with a pending value
    run_to(9);
    step(1'b1, 24'h987654);
    #2;
    rst = 1'b1;
    #1;
    n = 0; act = '0; shd = '0; pend = 1'b0; fr = 1'b0;
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    run(3 * FRAME);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sm_hex_scan.md
# sm_hex_scan

Digit scanner that sits directly upstream of the hex-to-seven-segment decoder. It holds a multi-digit hex value and presents one nibble at a time on a 4-bit digit bus, with a one-hot digit select and a blank flag. Updates are double-buffered and applied only at frame boundaries, so a displayed frame never mixes old and new digits. Leading-zero blanking is optional.

## Interface
- `DIGITS`, 6: number of hex digits scanned; must be ≥ 2.
- `DIV_W`, 16: prescaler width; one scan tick every 2^DIV_W clocks; must be ≥ 1.

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `load`  in  1  capture `value` into the shadow register on this clock edge
- `value`  in  4*DIGITS  digit i is `value[4*i+3:4*i]`; digit 0 is least significant
- `digit`  out  4  nibble of the currently selected digit; feeds the decoder
- `digit_sel`  out  DIGITS  one-hot, active-high select of the current digit position
- `blank`  out  1  current position must be shown dark
- `frame`  out  1  one-cycle pulse marking the start of a new frame
- `pending`  out  1  shadow holds a value not yet applied

## Operation
- Registers:
  - prescaler `cnt` (DIV_W bits)
  - scan index `idx` (0..DIGITS-1)
  - `active` and `shadow` (4*DIGITS bits each)
  - `pending`
  - `frame`
- Tick: asserted when `cnt` equals all-ones. `cnt` free-runs and wraps to 0 on the same edge.
- On a tick edge:
  - If `idx == DIGITS-1`, `idx` goes to 0 (wrap). Otherwise `idx` increments.
- On a wrap edge:
  - `frame` is set to 1.
  - If `pending` was 1, `active <= shadow` and `pending <= 0`.
- On every other edge, `frame` is 0.
- `load` edge: `shadow <= value` and `pending <= 1`. `load` has priority over a wrap's clear of `pending`.
- Simultaneous `load` and wrap:
  - `active` takes the old `shadow`.
  - `shadow` takes the new `value`.
  - `pending` stays 1.
- Back-to-back loads overwrite `shadow`; only the last one before a wrap is displayed.
- Outputs:
  - `digit = active[4*idx+3:4*idx]`
  - `digit_sel = 1 << idx`
  - All are decoded from registers only; there is no combinational path from inputs to outputs.
- `blank` depends on `SM_HEX_SCAN_LZB_EN` (see Configuration).

## Timing
- Reset values:
  - `cnt = 0`, `idx = 0`, `active = 0`, `shadow = 0`
  - `pending = 0`, `frame = 0`
  - So `digit = 0`, `digit_sel = 1` (position 0 selected), `blank = 0`
- Reset asserted mid-frame or mid-update: all state returns to the reset values immediately. Any pending shadow value is discarded.
- Dwell per digit: 2^DIV_W clocks. Frame length: DIGITS*2^DIV_W clocks.
- `digit`, `digit_sel` and `blank` change in the cycle after the tick edge; all three change together.
- `pending` rises one cycle after the `load` edge.
- Latency from `load` to display:
  - `active` updates on the next wrap edge.
  - Worst case is DIGITS*2^DIV_W clocks.
  - A load on the wrap edge itself takes effect one frame later.
- First wrap after reset occurs at clock DIGITS*2^DIV_W (counting the first edge after reset release as clock 1). `frame` is high for the following cycle.

## Configuration
- `SM_HEX_SCAN_LZB_EN` defined:
  - `blank = 1` when `idx > 0` and every `active` digit at position ≥ `idx` is zero.
  - Position 0 is never blanked.
  - `blank` is decoded from `active` and `idx`.
- `SM_HEX_SCAN_LZB_EN` undefined:
  - `blank` is tied to 0.
  - No blanking logic is synthesised.

## Test plan
Parameters for all scenarios: DIGITS=6, DIV_W=2 (tick every 4 clocks, frame 24 clocks).
1. Reset, then free-run 48 clocks → `digit_sel` steps 000001→000010→…→100000→000001 every 4 clocks. `frame` pulses once per 24 clocks, the first at clock 25. `digit = 0` throughout. `pending = 0`.
2. Mid-frame (idx=2), `load`=1 with `value`=24'h123456 → `pending`=1 on the next cycle. Positions 3–5 still show 0. After the wrap, position 0→5 shows 6,5,4,3,2,1 and `pending`=0.
3. Two loads in one frame, 24'hAAAAAA then 24'h0000BC → only 0000BC appears after the wrap. AAAAAA is never shown.
4. `load` of 24'hFFFFFF on the exact wrap edge while the shadow holds 24'h111111 and `pending`=1 → the new frame shows 111111 and `pending` stays 1. The next frame shows FFFFFF.
5. With `SM_HEX_SCAN_LZB_EN` and `active`=24'h00A00B:
   - `blank` = 0,0,0,0,1,1 for idx 0..5.
   - With `active`=0: `blank` = 0,1,1,1,1,1.
   - Without the macro, `blank` = 0 always.
6. Assert `rst` mid-frame with `pending`=1 → outputs return to their reset values asynchronously. After release, the pending value is never displayed.
